// File: rtl/audioqsys_mem_arbiter.sv
// Round-robin arbiter sharing one single-port sample memory between the host
// (port A) and the audio streaming reader (port B). One access per clock,
// 1-cycle read latency with readdatavalid routed back to the issuing port.
module audioqsys_mem_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // port A (host)
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  // port B (streaming reader)
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  // memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e prio_q, prio_d;
  port_e rd_id_q, rd_id_d;
  logic  rd_pend_q, rd_pend_d;
  logic  a_req, b_req;
  logic  grant_a, grant_b;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  // Grant decision; gated by reset_n so nothing is accepted while in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (a_req && b_req) begin
        grant_a = (prio_q == PORT_A);
        grant_b = (prio_q == PORT_B);
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_waitrequest  = ~grant_a;
  assign b_waitrequest  = ~grant_b;
  assign mem_chipselect = grant_a | grant_b;
  assign mem_clken      = reset_n;

  // Route the granted port onto the memory pins; reads enable every byte lane.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (grant_b) begin
      mem_address    = b_address;
      mem_write      = b_write;
      mem_writedata  = b_writedata;
      mem_byteenable = b_write ? b_byteenable : '1;
    end else if (grant_a) begin
      mem_address    = a_address;
      mem_write      = a_write;
      mem_writedata  = a_writedata;
      mem_byteenable = a_write ? a_byteenable : '1;
    end
  end

  // Next priority pointer and read-return tag; write wins over a simultaneous read.
  always_comb begin
    prio_d    = prio_q;
    rd_id_d   = rd_id_q;
    rd_pend_d = 1'b0;
    if (grant_a) begin
      prio_d    = PORT_B;
      rd_id_d   = PORT_A;
      rd_pend_d = a_read & ~a_write;
    end else if (grant_b) begin
      prio_d    = PORT_A;
      rd_id_d   = PORT_B;
      rd_pend_d = b_read & ~b_write;
    end
  end

  // State registers; async reset drops any in-flight read tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q    <= PORT_A;
      rd_id_q   <= PORT_A;
      rd_pend_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rd_id_q   <= rd_id_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign a_readdatavalid = rd_pend_q & (rd_id_q == PORT_A);
  assign b_readdatavalid = rd_pend_q & (rd_id_q == PORT_B);
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_audioqsys_mem_arbiter.sv
// Bench for audioqsys_mem_arbiter: a behavioural memory behind the arbiter and
// a transaction-level reference model predicting grants and read returns.
module tb_audioqsys_mem_arbiter;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] a_address, b_address;
  logic          a_read, a_write, b_read, b_write;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic [DW-1:0] a_writedata, b_writedata;
  logic          a_waitrequest, b_waitrequest;
  logic [DW-1:0] a_readdata, b_readdata;
  logic          a_readdatavalid, b_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audioqsys_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] init_word(input logic [14:0] a);
    if (a == 15'h0010) return 32'hDEADBEEF;
    if (a == 15'h7FFF) return 32'hAAAAAAAA;
    return {2'b10, a, ~a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Behavioural single-port synchronous memory, 1-cycle read latency.
  logic [31:0] sram [0:32767];
  bit          written [0:32767];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        sram[mem_address]    <= merge(written[mem_address] ? sram[mem_address]
                                      : init_word(mem_address), mem_writedata, mem_byteenable);
        written[mem_address] <= 1'b1;
      end else begin
        mem_readdata <= written[mem_address] ? sram[mem_address] : init_word(mem_address);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  int          m_prio;   // 0: A wins a tie, 1: B wins a tie
  int          m_win;    // -1 none, 0 A, 1 B
  bit          m_pend;
  int          m_port;
  logic [31:0] m_data;
  logic [4:0]  exp_vec;  // {a_wait, b_wait, cs, a_rdv, b_rdv}

  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic model_reset();
    m_prio = 0;
    m_pend = 1'b0;
  endtask

  task automatic model_eval();
    bit ar, br;
    ar = a_read | a_write;
    br = b_read | b_write;
    if (!reset_n)       m_win = -1;
    else if (ar && br)  m_win = m_prio;
    else if (ar)        m_win = 0;
    else if (br)        m_win = 1;
    else                m_win = -1;
    exp_vec = {m_win != 0, m_win != 1, m_win != -1,
               m_pend && (m_port == 0), m_pend && (m_port == 1)};
  endtask

  task automatic model_commit();
    logic [14:0] ad; logic [31:0] wd; logic [3:0] be; bit r, w;
    if (m_win == -1) begin
      m_pend = 1'b0;
      return;
    end
    if (m_win == 0) begin ad = a_address; wd = a_writedata; be = a_byteenable; r = a_read; w = a_write; end
    else            begin ad = b_address; wd = b_writedata; be = b_byteenable; r = b_read; w = b_write; end
    m_data = ref_rd(ad);
    if (w) ref_mem[int'(ad)] = merge(ref_rd(ad), wd, be);
    m_pend = r && !w;
    m_port = m_win;
    m_prio = (m_win == 0) ? 1 : 0;
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input bit ar, input bit aw, input logic [14:0] aa, input logic [3:0] abe,
                       input logic [31:0] awd, input bit br, input bit bw, input logic [14:0] ba,
                       input logic [3:0] bbe, input logic [31:0] bwd);
    a_read = ar; a_write = aw; a_address = aa; a_byteenable = abe; a_writedata = awd;
    b_read = br; b_write = bw; b_address = ba; b_byteenable = bbe; b_writedata = bwd;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] obs;
    reset_n = 1'b0;
    drive(1, 0, 15'h0003, '1, '0, 1, 0, 15'h0004, '1, '0);
    model_reset();
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b11000); end
    total++; if (mem_clken !== 1'b0) begin bad++; $display("FAIL reset_clken: got %b want 0", mem_clken); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
    settle();
    total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL run_clken: got %b want 1", mem_clken); end
    advance();
  endtask

  task automatic test_single_read();
    logic [4:0] obs;
    drive(1, 0, 15'h0010, '0, '0, 0, 0, '0, '0, '0);
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== exp_vec) begin bad++; $display("FAIL single_read_grant: got %b want %b", obs, exp_vec); end
    total++; if (mem_address !== 15'h0010 || mem_byteenable !== 4'hF || mem_write !== 1'b0) begin
      bad++; $display("FAIL single_read_mux: got addr=%h be=%h wr=%b want 0010 f 0", mem_address, mem_byteenable, mem_write);
    end
    advance();
    idle();
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== 5'b11010) begin bad++; $display("FAIL single_read_rdv: got %b want %b", obs, 5'b11010); end
    total++; if (a_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_read_data: got %h want deadbeef", a_readdata); end
    advance();
  endtask

  task automatic run_cycles(input string name, input int n, input int mode);
    // mode 0: both read, 1: B only reads, 2: random mixed traffic
    logic [4:0] obs; logic [31:0] od;
    for (int c = 0; c < n; c++) begin
      case (mode)
        0: drive(1, 0, 15'($urandom_range(0, 63)), '0, '0, 1, 0, 15'($urandom_range(0, 63)), '0, '0);
        1: drive(0, 0, '0, '0, '0, 1, 0, 15'($urandom_range(0, 63)), '0, '0);
        default: begin
          int ka, kb;
          ka = $urandom_range(0, 3); kb = $urandom_range(0, 3);
          drive(ka == 1, ka == 2, 15'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 15'h7FF8 : 15'h0),
                4'($urandom), $urandom,
                kb == 1, kb == 2, 15'($urandom_range(0, 7)), 4'($urandom), $urandom);
        end
      endcase
      settle();
      obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
      total++; if (obs !== exp_vec) begin bad++; $display("FAIL %s cyc%0d ctrl: got %b want %b", name, c, obs, exp_vec); end
      if (exp_vec[1] || exp_vec[0]) begin
        od = exp_vec[1] ? a_readdata : b_readdata;
        total++; if (od !== m_data) begin bad++; $display("FAIL %s cyc%0d data: got %h want %h", name, c, od, m_data); end
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    pulse_reset();
    run_cycles("alternate", 6, 0);
    run_cycles("alt_drain", 0, 0);
    idle();
    run_cycles("alt_tail", 0, 0);
  endtask

  task automatic test_byte_write();
    logic [4:0] obs;
    drive(0, 1, 15'h7FFF, 4'b0011, 32'h12345678, 0, 0, '0, '0, '0);
    settle();
    total++; if (mem_write !== 1'b1 || a_waitrequest !== 1'b0 || mem_byteenable !== 4'b0011) begin
      bad++; $display("FAIL byte_write_mux: got wr=%b wait=%b be=%b want 1 0 0011", mem_write, a_waitrequest, mem_byteenable);
    end
    advance();
    drive(0, 0, '0, '0, '0, 1, 0, 15'h7FFF, '0, '0);
    settle();
    advance();
    idle();
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== 5'b11001) begin bad++; $display("FAIL byte_write_rdv: got %b want %b", obs, 5'b11001); end
    total++; if (b_readdata !== 32'hAAAA5678) begin bad++; $display("FAIL byte_write_data: got %h want aaaa5678", b_readdata); end
    advance();
  endtask

  task automatic test_lone_b();
    pulse_reset();
    run_cycles("lone_b", 4, 1);
    run_cycles("lone_b_tie", 4, 0);
    idle();
    settle();
    advance();
  endtask

  task automatic test_reset_mid_read();
    logic [4:0] obs;
    drive(1, 0, 15'h0010, '0, '0, 0, 0, '0, '0, '0);
    settle();
    total++; if (a_waitrequest !== 1'b0) begin bad++; $display("FAIL midrst_accept: got wait=%b want 0", a_waitrequest); end
    advance();
    reset_n = 1'b0;
    model_reset();
    drive(1, 0, 15'h0011, '0, '0, 1, 0, 15'h0012, '0, '0);
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== 5'b11000) begin bad++; $display("FAIL midrst_in_reset: got %b want %b", obs, 5'b11000); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle();
      settle();
      total++; if (a_readdatavalid !== 1'b0) begin bad++; $display("FAIL midrst_after%0d: got rdv=%b want 0", c, a_readdatavalid); end
      advance();
    end
  endtask

  task automatic test_rw_both();
    logic [4:0] obs; logic [31:0] wd;
    wd = $urandom;
    drive(1, 1, 15'h0001, 4'hF, wd, 0, 0, '0, '0, '0);
    settle();
    total++; if (mem_write !== 1'b1 || a_waitrequest !== 1'b0 || mem_address !== 15'h0001) begin
      bad++; $display("FAIL rw_both_write: got wr=%b wait=%b addr=%h want 1 0 0001", mem_write, a_waitrequest, mem_address);
    end
    advance();
    drive(1, 0, 15'h0001, '0, '0, 0, 0, '0, '0, '0);
    settle();
    total++; if (a_readdatavalid !== 1'b0) begin bad++; $display("FAIL rw_both_nordv: got %b want 0", a_readdatavalid); end
    advance();
    idle();
    settle();
    obs = {a_waitrequest, b_waitrequest, mem_chipselect, a_readdatavalid, b_readdatavalid};
    total++; if (obs !== 5'b11010 || a_readdata !== wd) begin
      bad++; $display("FAIL rw_both_readback: got %b/%h want 11010/%h", obs, a_readdata, wd);
    end
    advance();
  endtask

  task automatic test_random();
    run_cycles("random", 300, 2);
    idle();
    settle();
    advance();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_byte_write();
    test_lone_b();
    test_reset_mid_read();
    test_rw_both();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
